// File: rtl/regfile_nport_pkg.sv
// Shared constants for the register file: datapath width, default depth and the hardwired-zero index.
package regfile_nport_pkg;
    localparam int XLEN      = 16;
    localparam int DEF_DEPTH = 8;
    localparam int REG_ZERO  = 0;
endpackage

// File: rtl/regfile_nport_dff_nbit.sv
// One stored word: per-byte write enables and synchronous active-high clear.
// Single-cycle update; reset wins over any byte write in the same cycle.
module regfile_nport_dff_nbit
    import regfile_nport_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH/8-1:0]   WE,
    input  logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     Q
);
    localparam int NB = WIDTH / 8;

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (WE[i]) Q[8*i +: 8] <= D[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/regfile_nport.sv
// DEPTH x WIDTH register file: one byte-enabled write port, NUM_RD combinational read ports.
// Reads are zero-latency; optional same-cycle write-to-read bypass is suppressed during reset.
module regfile_nport
    import regfile_nport_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WE,
    input  logic [$clog2(DEPTH)-1:0]  WADDR,
    input  logic [WIDTH-1:0]          WDATA,
    input  logic [WIDTH/8-1:0]        WBE,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] RADDR,
    output logic [NUM_RD*WIDTH-1:0]   RDATA
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        if (ZERO_R0 != 0 && k == REG_ZERO) begin : g_zero
            assign mem[k] = '0;
        end else begin : g_store
            logic [NB-1:0] byte_we;
            // WE gates everything first so X on WADDR/WBE cannot reach the storage while idle.
            assign byte_we = {NB{WE && (WADDR == AW'(k))}} & WBE;

            regfile_nport_dff_nbit #(.WIDTH(WIDTH)) u_word (
                .CLK (CLK),
                .RST (RST),
                .WE  (byte_we),
                .D   (WDATA),
                .Q   (mem[k])
            );
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    raddr;
        logic [WIDTH-1:0] stored;
        logic [WIDTH-1:0] merged;
        logic             is_zero;
        logic             hit;

        assign raddr   = RADDR[p*AW +: AW];
        assign stored  = mem[raddr];
        assign is_zero = (ZERO_R0 != 0) && (raddr == AW'(REG_ZERO));
        assign hit     = (BYPASS != 0) && WE && !RST && (raddr == WADDR) && !is_zero;

        for (genvar i = 0; i < NB; i++) begin : g_byte
            assign merged[8*i +: 8] = WBE[i] ? WDATA[8*i +: 8] : stored[8*i +: 8];
        end

        assign RDATA[p*WIDTH +: WIDTH] = is_zero ? '0 : (hit ? merged : stored);
    end
endmodule
